// File: rtl/ring_counter_pkg.sv
// Shared helpers for the one-hot ring counter: reset-pattern builder, one-hot check
// and the legal width range.
package ring_counter_pkg;

   localparam int RC_N_MIN = 2;
   localparam int RC_N_MAX = 64;

   typedef logic [RC_N_MAX-1:0] rc_vec_t;

   // Out-of-range positions fall back to bit 0 so the pattern is always one-hot.
   function automatic rc_vec_t rc_onehot_pattern(input int n, input int pos);
      rc_vec_t v;
      v = '0;
      if (pos >= 0 && pos < n && pos < RC_N_MAX)
         v[pos] = 1'b1;
      else
         v[0] = 1'b1;
      return v;
   endfunction

   function automatic logic rc_is_onehot(input rc_vec_t v);
      return (v != '0) && ((v & (v - rc_vec_t'(1))) == '0);
   endfunction

endpackage

// File: rtl/ring_onehot_check.sv
// Combinational population check: o_is_onehot is high when exactly one bit of
// i_vec is set.
module ring_onehot_check
   import ring_counter_pkg::*;
#(
   parameter int N = 4
)(
   input  logic [N-1:0] i_vec,
   output logic         o_is_onehot
);

   rc_vec_t w_ext;

   always_comb begin
      w_ext         = '0;
      w_ext[N-1:0]  = i_vec;
   end

   assign o_is_onehot = rc_is_onehot(w_ext);

endmodule

// File: rtl/ring_counter.sv
// Free-running one-hot ring counter with illegal-state self-correction.
// Define RING_COUNTER_ERR_EN to add the registered err output.
module ring_counter
   import ring_counter_pkg::*;
#(
   parameter int N          = 4,
   parameter bit SHIFT_LEFT = 1'b1,
   parameter int INIT_POS   = 0
)(
   input  logic         clk,
   input  logic         rst,
`ifdef RING_COUNTER_ERR_EN
   output logic         err,
`endif
   output logic [N-1:0] count
);

   if (N < RC_N_MIN || N > RC_N_MAX) begin : g_bad_n
      $error("ring_counter: N=%0d outside %0d..%0d", N, RC_N_MIN, RC_N_MAX);
   end
   if (INIT_POS < 0 || INIT_POS >= N) begin : g_bad_pos
      $error("ring_counter: INIT_POS=%0d outside 0..%0d", INIT_POS, N - 1);
   end

   localparam rc_vec_t        RST_FULL = rc_onehot_pattern(N, INIT_POS);
   localparam logic [N-1:0]   RST_PAT  = RST_FULL[N-1:0];

   logic [N-1:0] r_count;
   logic [N-1:0] w_rot;
   logic [N-1:0] w_next;
   logic         w_onehot;

   ring_onehot_check #(.N(N)) u_check (
      .i_vec       (r_count),
      .o_is_onehot (w_onehot)
   );

   always_comb begin
      w_rot = r_count;
      if (SHIFT_LEFT)
         w_rot = {r_count[N-2:0], r_count[N-1]};
      else
         w_rot = {r_count[0], r_count[N-1:1]};
   end

   // A corrupted ring (zero or multiple bits) reloads the reset pattern instead of rotating.
   assign w_next = w_onehot ? w_rot : RST_PAT;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_count <= RST_PAT;
      else
         r_count <= w_next;
   end

   assign count = r_count;

`ifdef RING_COUNTER_ERR_EN
   logic r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_err <= 1'b0;
      else
         r_err <= ~w_onehot;
   end

   assign err = r_err;
`endif

endmodule

// File: tb/tb_ring_counter.sv
// Directed bench for ring_counter: default 4-bit left ring plus an 8-bit right ring
// with INIT_POS=3, covering reset hold, free-run, async mid-run reset and self-correction.
module tb_ring_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] count4;
   logic [7:0] count8;
`ifdef RING_COUNTER_ERR_EN
   logic       err4;
   logic       err8;
`endif

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ring_counter #(.N(4), .SHIFT_LEFT(1'b1), .INIT_POS(0)) u_dut (
      .clk   (clk),
      .rst   (rst),
`ifdef RING_COUNTER_ERR_EN
      .err   (err4),
`endif
      .count (count4)
   );

   ring_counter #(.N(8), .SHIFT_LEFT(1'b0), .INIT_POS(3)) u_dut8 (
      .clk   (clk),
      .rst   (rst),
`ifdef RING_COUNTER_ERR_EN
      .err   (err8),
`endif
      .count (count8)
   );

   logic [3:0] seq4 [4] = '{4'h2, 4'h4, 4'h8, 4'h1};
   logic [7:0] seq8 [8] = '{8'h04, 8'h02, 8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_err(input string tag, input logic exp);
`ifdef RING_COUNTER_ERR_EN
      chk({tag, "_err4"}, 64'(err4), 64'(exp));
      chk({tag, "_err8"}, 64'(err8), 64'(exp));
`else
      if (exp) begin end
      if (tag.len() == 0) begin end
`endif
   endtask

   task automatic run_seq(input string tag);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk({tag, "4"}, 64'(count4), 64'(seq4[i % 4]));
         chk({tag, "8"}, 64'(count8), 64'(seq8[i]));
         chk({tag, "_onehot8"}, 64'($countones(count8)), 64'd1);
         chk_err(tag, 1'b0);
      end
   endtask

   initial begin
      // reset hold across edges at 5 and 15 ns
      @(negedge clk);
      chk("rst_hold4_10", 64'(count4), 64'h1);
      chk("rst_hold8_10", 64'(count8), 64'h08);
      chk_err("rst_hold", 1'b0);
      @(negedge clk);
      chk("rst_hold4_20", 64'(count4), 64'h1);
      chk("rst_hold8_20", 64'(count8), 64'h08);
      rst = 1'b0;

      run_seq("run");

      // mid-run async reset at 100 ns, checked before the next edge
      rst = 1'b1;
      #1;
      chk("async4", 64'(count4), 64'h1);
      chk("async8", 64'(count8), 64'h08);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rst_mid4", 64'(count4), 64'h1);
         chk("rst_mid8", 64'(count8), 64'h08);
         chk_err("rst_mid", 1'b0);
      end
      rst = 1'b0;

      run_seq("restart");

      // multiple bits set in the 4-bit ring, all zeros in the 8-bit ring
      force u_dut.r_count  = 4'b0110;
      force u_dut8.r_count = 8'h00;
      #1;
      release u_dut.r_count;
      release u_dut8.r_count;
      chk("forced4", 64'(count4), 64'h6);
      @(negedge clk);
      chk("fix4", 64'(count4), 64'h1);
      chk("fix8", 64'(count8), 64'h08);
      chk_err("fix", 1'b1);
      @(negedge clk);
      chk("after_fix4", 64'(count4), 64'h2);
      chk("after_fix8", 64'(count8), 64'h04);
      chk_err("after_fix", 1'b0);

      force u_dut.r_count = 4'b0000;
      #1;
      release u_dut.r_count;
      @(negedge clk);
      chk("fix_zero4", 64'(count4), 64'h1);
`ifdef RING_COUNTER_ERR_EN
      chk("fix_zero_err4", 64'(err4), 64'd1);
      chk("fix_zero_err8", 64'(err8), 64'd0);
`endif
      chk("fix_zero_8run", 64'(count8), 64'h02);
      @(negedge clk);
      chk("after_zero4", 64'(count4), 64'h2);
      chk_err("after_zero", 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ring_counter.md
Name: ring_counter

Overview:
- Parameterised one-hot ring counter: a single set bit circulates through an N-bit register, advancing one position per clock.
- Used as a sequencer or phase generator. Each output bit is high for exactly one cycle in every N.
- Free-running; no enable or load inputs. Includes illegal-state self-correction so a corrupted register always returns to a legal one-hot state.

Parameters:
- N, 4, counter width and ring length; legal range 2..64.
- SHIFT_LEFT, 1, 1 = rotate toward MSB (bit i moves to bit i+1, MSB wraps to bit 0); 0 = rotate toward LSB.
- INIT_POS, 0, bit index set at reset; legal range 0..N-1.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- count, output, N, one-hot ring state, driven directly from a register.

Behaviour:
- Reset:
  - rst high asynchronously forces count to the one-hot value with only bit INIT_POS set. With the defaults this is 4'b0001 (decimal 1).
  - count holds that value for as long as rst is high. Clock edges are ignored during reset.
- Release:
  - On the first rising clk edge with rst low, count advances one position.
  - No internal synchronizer on rst deassertion; the surrounding design releases reset synchronously.
- Rotation with SHIFT_LEFT=1, N=4: 0001 -> 0010 -> 0100 -> 1000 -> 0001 (decimal 1, 2, 4, 8, 1).
  - Period is N cycles.
  - Wrap from MSB to bit 0 happens in a single cycle, with no idle state.
- Rotation with SHIFT_LEFT=0, N=4: 0001 -> 1000 -> 0100 -> 0010 -> 0001.
- Latency: count changes exactly one clk edge after each advance; outputs are registered, with no combinational path from inputs.
- Self-correction:
  - If count is not exactly one-hot (all zeros or more than one bit set, e.g. after an SEU), the next edge loads the reset pattern instead of rotating.
  - One-hot detection is a combinational population check on the current register value.
- Reset mid-run: asserting rst at any point in the sequence immediately (asynchronously) returns count to the reset pattern. After release, the sequence restarts from the reset pattern.
- Invariant (outside reset transients): exactly one bit of count is high at every clock edge.

Optional Feature:
- Macro: RING_COUNTER_ERR_EN.
- Defined:
  - Adds output port err (1 bit, registered).
  - err is high for one cycle on the edge at which self-correction reloads the counter, i.e. it reports that the previous state was not one-hot.
  - err resets to 0.
- Not defined:
  - No err port.
  - Self-correction still operates silently.
  - Port list is exactly clk, rst, count.

Decomposition:
- Package ring_counter_pkg holds:
  - the function that builds the one-hot reset pattern from N and INIT_POS;
  - the one-hot check function (true when exactly one bit is set);
  - localparam bounds for the legal N range.
- Sub-module ring_onehot_check (input vector N bits, output is_onehot) wraps the check. It is reused by the optional err logic and by verification assertions.
- Top module ring_counter holds the register, rotate mux and reset logic.

Test Plan:
- Reset hold: clk period 10 ns, rst=1 for 20 ns -> count = 1 throughout, unchanged across edges at 5 ns and 15 ns.
- Free-run: rst=0 at 20 ns, run 80 ns -> count sequence 2, 4, 8, 1, 2, 4, 8, 1 on successive rising edges (period 4).
- Mid-run reset: assert rst at 100 ns for 80 ns -> count = 1 immediately, before the next clock edge; it stays 1 for the full 80 ns.
- Restart: deassert rst at 180 ns, run 80 ns -> sequence restarts at 2, 4, 8, 1, ...
- Illegal state: force count to 4'b0110 (or 0000) then release the force -> next edge count = 0001. With RING_COUNTER_ERR_EN defined, err = 1 for exactly that cycle, otherwise 0.
- Parameter sweep: N=8, SHIFT_LEFT=0, INIT_POS=3 -> reset value 8'h08, then 04, 02, 01, 80, 40, ...; the one-hot invariant holds every cycle.
